hsv_window_masker: RTL and testbench

- Streaming HSV colour-segmentation stage that sits directly after the RGB-to-HSV converter in the pixel path.
- Compares each pixel against NUM_WIN programmable H/S/V threshold windows, for example one window per paddle colour and one for the ball.
- Outputs a per-window match mask and a masked pixel.
- Accumulates per-window matched-pixel counts over each frame, for the game-logic and tracking blocks downstream.

---
 rtl/hsv_window_masker_pkg.sv | 54 +++++
 rtl/hsv_window_masker_range_cmp.sv | 18 +
 rtl/hsv_window_masker.sv | 195 +++++++++++++++++++
 tb/tb_hsv_window_masker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_window_masker_pkg.sv
// Shared types for the HSV window masker: config field map, per-window
// threshold set and the config address decoder.
package hsv_window_masker_pkg;

    // Widest component the config storage can hold; narrower pixels are zero-extended.
    localparam int CFG_MAX_W = 16;

    typedef enum logic [1:0] {
        FLD_H  = 2'd0,
        FLD_S  = 2'd1,
        FLD_V  = 2'd2,
        FLD_EN = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [CFG_MAX_W-1:0] h_lo;
        logic [CFG_MAX_W-1:0] h_hi;
        logic [CFG_MAX_W-1:0] s_lo;
        logic [CFG_MAX_W-1:0] s_hi;
        logic [CFG_MAX_W-1:0] v_lo;
        logic [CFG_MAX_W-1:0] v_hi;
        logic                 en;
    } win_cfg_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] win;
        cfg_field_e field;
    } cfg_dec_t;

    function automatic cfg_dec_t decode_cfg_addr(input logic [4:0] addr, input int unsigned num_win);
        cfg_dec_t d;
        d.win   = addr[4:2];
        d.field = cfg_field_e'(addr[1:0]);
        d.hit   = ({29'd0, addr[4:2]} < num_win);
        return d;
    endfunction

    // Full-range, disabled window for a DATA_W-wide pixel.
    function automatic win_cfg_t cfg_reset_value(input int unsigned data_w);
        win_cfg_t             c;
        logic [CFG_MAX_W-1:0] top;
        top = '0;
        for (int unsigned i = 0; i < CFG_MAX_W; i++) begin
            if (i < data_w) top[i] = 1'b1;
        end
        c      = '0;
        c.h_hi = top;
        c.s_hi = top;
        c.v_hi = top;
        return c;
    endfunction

endpackage

// File: rtl/hsv_window_masker_range_cmp.sv
// Combinational lo/hi window compare; with wrap enabled an inverted range
// (lo > hi) matches the two outer segments, as needed for circular hue.
module hsv_range_cmp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_lo,
    input  logic [DATA_W-1:0] i_hi,
    input  logic              i_wrap_en,
    output logic              o_match
);

    always_comb begin
        if (i_lo <= i_hi) o_match = (i_x >= i_lo) && (i_x <= i_hi);
        else              o_match = i_wrap_en && ((i_x >= i_lo) || (i_x <= i_hi));
    end

endmodule

// File: rtl/hsv_window_masker.sv
// Two-stage HSV colour segmentation: per-window threshold match, masked pixel
// passthrough and saturating per-frame matched-pixel counters.
module hsv_window_masker
    import hsv_window_masker_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_WIN = 2,
    parameter int CNT_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [4:0]               cfg_addr,
    input  logic [2*DATA_W-1:0]      cfg_wdata,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_eof,
    input  logic [DATA_W-1:0]        in_h,
    input  logic [DATA_W-1:0]        in_s,
    input  logic [DATA_W-1:0]        in_v,
    output logic                     out_valid,
    output logic [NUM_WIN-1:0]       out_mask,
    output logic [DATA_W-1:0]        out_h,
    output logic [DATA_W-1:0]        out_s,
    output logic [DATA_W-1:0]        out_v,
    output logic                     cnt_valid,
    output logic [NUM_WIN*CNT_W-1:0] cnt_data
);

    localparam win_cfg_t CFG_RST = cfg_reset_value(DATA_W);

    win_cfg_t r_shadow [NUM_WIN];
    win_cfg_t r_active [NUM_WIN];
    win_cfg_t w_sel    [NUM_WIN];
    cfg_dec_t w_dec;
    logic     w_load;

    assign w_dec  = decode_cfg_addr(cfg_addr, NUM_WIN);
    assign w_load = in_valid && in_sof;

    // NOTE: the threshold arrays are only 2*NUM_WIN registers, so they get a real reset value rather than being left as uninitialised storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                r_shadow[w] <= CFG_RST;
                r_active[w] <= CFG_RST;
            end
        end else begin
            for (int w = 0; w < NUM_WIN; w++) begin
                if (w_load) r_active[w] <= r_shadow[w];
                if (cfg_we && w_dec.hit && (w_dec.win == 3'(w))) begin
                    case (w_dec.field)
                        FLD_H: begin
                            r_shadow[w].h_lo <= CFG_MAX_W'(cfg_wdata[DATA_W-1:0]);
                            r_shadow[w].h_hi <= CFG_MAX_W'(cfg_wdata[2*DATA_W-1:DATA_W]);
                        end
                        FLD_S: begin
                            r_shadow[w].s_lo <= CFG_MAX_W'(cfg_wdata[DATA_W-1:0]);
                            r_shadow[w].s_hi <= CFG_MAX_W'(cfg_wdata[2*DATA_W-1:DATA_W]);
                        end
                        FLD_V: begin
                            r_shadow[w].v_lo <= CFG_MAX_W'(cfg_wdata[DATA_W-1:0]);
                            r_shadow[w].v_hi <= CFG_MAX_W'(cfg_wdata[2*DATA_W-1:DATA_W]);
                        end
                        default: r_shadow[w].en <= cfg_wdata[0];
                    endcase
                end
            end
        end
    end

    // The sof pixel is judged against the thresholds it is about to load.
    always_comb begin
        for (int w = 0; w < NUM_WIN; w++) begin
            w_sel[w] = w_load ? r_shadow[w] : r_active[w];
        end
    end

    logic [NUM_WIN-1:0] w_h_hit, w_s_hit, w_v_hit, w_en;

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        assign w_en[g] = w_sel[g].en;
        hsv_range_cmp #(.DATA_W(CFG_MAX_W)) u_cmp_h (
            .i_x(CFG_MAX_W'(in_h)), .i_lo(w_sel[g].h_lo), .i_hi(w_sel[g].h_hi),
            .i_wrap_en(1'b1), .o_match(w_h_hit[g]));
        hsv_range_cmp #(.DATA_W(CFG_MAX_W)) u_cmp_s (
            .i_x(CFG_MAX_W'(in_s)), .i_lo(w_sel[g].s_lo), .i_hi(w_sel[g].s_hi),
            .i_wrap_en(1'b0), .o_match(w_s_hit[g]));
        hsv_range_cmp #(.DATA_W(CFG_MAX_W)) u_cmp_v (
            .i_x(CFG_MAX_W'(in_v)), .i_lo(w_sel[g].v_lo), .i_hi(w_sel[g].v_hi),
            .i_wrap_en(1'b0), .o_match(w_v_hit[g]));
    end

    logic               r1_valid, r1_sof, r1_eof;
    logic [NUM_WIN-1:0] r1_h_hit, r1_s_hit, r1_v_hit, r1_en;
    logic [DATA_W-1:0]  r1_h, r1_s, r1_v;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sof   <= 1'b0;
            r1_eof   <= 1'b0;
            r1_h_hit <= '0;
            r1_s_hit <= '0;
            r1_v_hit <= '0;
            r1_en    <= '0;
            r1_h     <= '0;
            r1_s     <= '0;
            r1_v     <= '0;
        end else begin
            r1_valid <= in_valid;
            r1_sof   <= in_valid && in_sof;
            r1_eof   <= in_valid && in_eof;
            r1_h_hit <= w_h_hit;
            r1_s_hit <= w_s_hit;
            r1_v_hit <= w_v_hit;
            r1_en    <= w_en;
            r1_h     <= in_h;
            r1_s     <= in_s;
            r1_v     <= in_v;
        end
    end

    logic [NUM_WIN-1:0] w_mask;
    logic               w_keep;

    assign w_mask = r1_h_hit & r1_s_hit & r1_v_hit & r1_en & {NUM_WIN{r1_valid}};
    assign w_keep = |w_mask;

    logic               r2_valid, r2_sof, r2_eof;
    logic [NUM_WIN-1:0] r2_mask;
    logic [DATA_W-1:0]  r2_h, r2_s, r2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sof   <= 1'b0;
            r2_eof   <= 1'b0;
            r2_mask  <= '0;
            r2_h     <= '0;
            r2_s     <= '0;
            r2_v     <= '0;
        end else begin
            r2_valid <= r1_valid;
            r2_sof   <= r1_sof;
            r2_eof   <= r1_eof;
            r2_mask  <= w_mask;
            r2_h     <= w_keep ? r1_h : '0;
            r2_s     <= w_keep ? r1_s : '0;
            r2_v     <= w_keep ? r1_v : '0;
        end
    end

    logic [CNT_W-1:0]         r_cnt      [NUM_WIN];
    logic [CNT_W-1:0]         w_cnt_next [NUM_WIN];
    logic [NUM_WIN*CNT_W-1:0] w_cnt_flat;
    logic                     r_cnt_valid;
    logic [NUM_WIN*CNT_W-1:0] r_cnt_data;

    // NOTE: every always_comb output is given a value before any condition, so no path can leave a latch behind.
    always_comb begin
        w_cnt_flat = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            w_cnt_next[w] = r2_sof ? '0 : r_cnt[w];
            if (r2_mask[w] && (w_cnt_next[w] != '1)) w_cnt_next[w] = w_cnt_next[w] + CNT_W'(1);
            w_cnt_flat[w*CNT_W +: CNT_W] = w_cnt_next[w];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WIN; w++) r_cnt[w] <= '0;
            r_cnt_valid <= 1'b0;
            r_cnt_data  <= '0;
        end else begin
            r_cnt_valid <= r2_eof;
            if (r2_eof) begin
                r_cnt_data <= w_cnt_flat;
                for (int w = 0; w < NUM_WIN; w++) r_cnt[w] <= '0;
            end else begin
                for (int w = 0; w < NUM_WIN; w++) r_cnt[w] <= w_cnt_next[w];
            end
        end
    end

    assign out_valid = r2_valid;
    assign out_mask  = r2_mask;
    assign out_h     = r2_h;
    assign out_s     = r2_s;
    assign out_v     = r2_v;
    assign cnt_valid = r_cnt_valid;
    assign cnt_data  = r_cnt_data;

endmodule

// File: tb/tb_hsv_window_masker.sv
// Self-checking bench: directed and random pixel streams against a cycle-indexed
// behavioural model; a second instance with 4-bit counters exercises saturation.
module tb_hsv_window_masker;

    localparam int DW    = 8;
    localparam int NW    = 2;
    localparam int CW    = 20;
    localparam int CWS   = 4;
    localparam int DEPTH = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [4:0]       cfg_addr = '0;
    logic [2*DW-1:0]  cfg_wdata = '0;
    logic             in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [DW-1:0]    in_h = '0, in_s = '0, in_v = '0;

    logic             out_valid, cnt_valid;
    logic [NW-1:0]    out_mask;
    logic [DW-1:0]    out_h, out_s, out_v;
    logic [NW*CW-1:0] cnt_data;

    logic              sat_out_valid, sat_cnt_valid;
    logic [NW-1:0]     sat_out_mask;
    logic [DW-1:0]     sat_out_h, sat_out_s, sat_out_v;
    logic [NW*CWS-1:0] sat_cnt_data;

    hsv_window_masker #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_h(in_h), .in_s(in_s), .in_v(in_v),
        .out_valid(out_valid), .out_mask(out_mask), .out_h(out_h), .out_s(out_s), .out_v(out_v),
        .cnt_valid(cnt_valid), .cnt_data(cnt_data));

    hsv_window_masker #(.DATA_W(DW), .NUM_WIN(NW), .CNT_W(CWS)) u_dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_h(in_h), .in_s(in_s), .in_v(in_v),
        .out_valid(sat_out_valid), .out_mask(sat_out_mask),
        .out_h(sat_out_h), .out_s(sat_out_s), .out_v(sat_out_v),
        .cnt_valid(sat_cnt_valid), .cnt_data(sat_cnt_data));

    always #5 clk = ~clk;

    // Expected DUT outputs, indexed by the cycle in which they must be visible.
    logic              e_valid [DEPTH];
    logic [NW-1:0]     e_mask  [DEPTH];
    logic [DW-1:0]     e_h [DEPTH], e_s [DEPTH], e_v [DEPTH];
    logic              e_cv    [DEPTH];
    logic [NW*CW-1:0]  e_cd    [DEPTH];
    logic [NW*CWS-1:0] e_cds   [DEPTH];

    int sh_lo [NW][3], sh_hi [NW][3], ac_lo [NW][3], ac_hi [NW][3];
    bit sh_en [NW], ac_en [NW];
    int cnt   [NW];
    logic [NW*CW-1:0]  held_cd;
    logic [NW*CWS-1:0] held_cds;

    int checks = 0, failures = 0, cyc = 0;
    bit armed = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit in_rng(input int x, input int lo, input int hi, input bit wrap);
        if (lo <= hi) return (x >= lo) && (x <= hi);
        return wrap && ((x >= lo) || (x <= hi));
    endfunction

    function automatic int sat(input int x, input int w);
        int top = (1 << w) - 1;
        return (x > top) ? top : x;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            for (int f = 0; f < 3; f++) begin
                sh_lo[w][f] = 0; sh_hi[w][f] = 255;
                ac_lo[w][f] = 0; ac_hi[w][f] = 255;
            end
            sh_en[w] = 0; ac_en[w] = 0; cnt[w] = 0;
        end
        held_cd  = '0;
        held_cds = '0;
    endtask

    task automatic clear_exp(input int c);
        e_valid[c] = 0; e_mask[c] = '0; e_h[c] = '0; e_s[c] = '0; e_v[c] = '0;
        e_cv[c] = 0; e_cd[c] = '0; e_cds[c] = '0;
    endtask

    // One clock: check the current outputs, drive this cycle's inputs, advance the model.
    task automatic tick(input bit v, input bit sf, input bit ef, input int h, input int s,
                        input int vv, input bit we, input int addr, input int wd, input bit r);
        logic [NW-1:0] m;
        @(negedge clk);
        if (armed) begin
            check("out_valid", 64'(out_valid), 64'(e_valid[cyc]));
            check("out_mask",  64'(out_mask),  64'(e_mask[cyc]));
            check("out_h",     64'(out_h),     64'(e_h[cyc]));
            check("out_s",     64'(out_s),     64'(e_s[cyc]));
            check("out_v",     64'(out_v),     64'(e_v[cyc]));
            check("cnt_valid", 64'(cnt_valid), 64'(e_cv[cyc]));
            check("cnt_data",  64'(cnt_data),  64'(e_cd[cyc]));
            check("sat_cnt_data", 64'(sat_cnt_data), 64'(e_cds[cyc]));
            check("sat_cnt_valid", 64'(sat_cnt_valid), 64'(e_cv[cyc]));
        end
        rst = r; in_valid = v; in_sof = sf; in_eof = ef;
        in_h = DW'(h); in_s = DW'(s); in_v = DW'(vv);
        cfg_we = we; cfg_addr = 5'(addr); cfg_wdata = 16'(wd);
        if (r) begin
            model_reset();
            for (int k = 1; k <= 3; k++) clear_exp(cyc + k);
            armed = 1'b1;
        end else begin
            if (v && sf) begin
                ac_lo = sh_lo; ac_hi = sh_hi; ac_en = sh_en;
            end
            m = '0;
            for (int w = 0; w < NW; w++)
                m[w] = v && ac_en[w] && in_rng(h, ac_lo[w][0], ac_hi[w][0], 1'b1)
                       && in_rng(s, ac_lo[w][1], ac_hi[w][1], 1'b0)
                       && in_rng(vv, ac_lo[w][2], ac_hi[w][2], 1'b0);
            e_valid[cyc+2] = v;
            e_mask[cyc+2]  = m;
            e_h[cyc+2] = (m != 0) ? DW'(h)  : '0;
            e_s[cyc+2] = (m != 0) ? DW'(s)  : '0;
            e_v[cyc+2] = (m != 0) ? DW'(vv) : '0;
            e_cv[cyc+3] = 0;
            if (v) begin
                for (int w = 0; w < NW; w++) begin
                    if (sf) cnt[w] = 0;
                    cnt[w] += int'(m[w]);
                end
                if (ef) begin
                    for (int w = 0; w < NW; w++) begin
                        held_cd[w*CW +: CW]   = CW'(sat(cnt[w], CW));
                        held_cds[w*CWS +: CWS] = CWS'(sat(cnt[w], CWS));
                        cnt[w] = 0;
                    end
                    e_cv[cyc+3] = 1;
                end
            end
            e_cd[cyc+3]  = held_cd;
            e_cds[cyc+3] = held_cds;
            if (we && addr < NW*4) begin
                if (addr % 4 < 3) begin
                    sh_lo[addr/4][addr%4] = wd & 255;
                    sh_hi[addr/4][addr%4] = (wd >> 8) & 255;
                end else begin
                    sh_en[addr/4] = wd[0];
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic px(input bit sf, input bit ef, input int h, input int s, input int v);
        tick(1, sf, ef, h, s, v, 0, 0, 0, 0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic cfgw(input int addr, input int wd);
        tick(0, 0, 0, 0, 0, 0, 1, addr, wd, 0);
    endtask
    task automatic reset_tick();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) clear_exp(i);
        model_reset();
        reset_tick();
        reset_tick();

        // Unconfigured: everything masked, zero counts at eof.
        for (int i = 0; i < 10; i++)
            px(i == 0, i == 9, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        idle(4);

        // Window 0: H 20..40, S 100..255, V 50..255.
        cfgw(0, 16'h2814); cfgw(1, 16'hFF64); cfgw(2, 16'hFF32); cfgw(3, 1);
        px(1, 0, 30, 150, 200);
        px(0, 1, 41, 150, 200);
        idle(3);

        // Window 1: wrapped hue 240..10.
        cfgw(4, 16'h0AF0); cfgw(5, 16'hFF00); cfgw(6, 16'hFF00); cfgw(7, 1);
        px(1, 0, 250, 150, 200);
        px(0, 0, 5, 150, 200);
        px(0, 1, 11, 150, 200);
        idle(3);

        // Shadow timing: mid-frame write, then a write on the sof cycle itself.
        px(1, 0, 30, 150, 200);
        tick(1, 0, 0, 30, 150, 200, 1, 0, 16'h645A, 0);
        px(0, 0, 30, 150, 200);
        px(0, 1, 95, 150, 200);
        tick(1, 1, 0, 95, 150, 200, 1, 0, 16'h2814, 0);
        px(0, 0, 30, 150, 200);
        px(0, 1, 95, 150, 200);
        px(1, 1, 30, 150, 200);
        idle(3);

        // 100-pixel frame: 37 hits on window 0, all hits on a full-range window 1.
        cfgw(4, 16'hFF00);
        for (int i = 0; i < 100; i++)
            px(i == 0, i == 99, (i < 37) ? 30 : 100, 150, 200);
        idle(4);
        check("frame100_counts", 64'(cnt_data), 64'({20'd100, 20'd37}));
        check("frame100_sat_counts", 64'(sat_cnt_data), 64'({4'd15, 4'd15}));
        for (int i = 0; i < 5; i++) px(i == 0, i == 4, 100, 150, 200);
        idle(4);
        check("next_frame_cleared", 64'(cnt_data), 64'({20'd5, 20'd0}));

        // Random stream with live reconfiguration, gaps and odd framing.
        for (int i = 0; i < 700; i++) begin
            int wd;
            bit we;
            wd = ($urandom_range(0, 1) == 1) ? (int'($urandom_range(128, 255)) << 8) | int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, 65535));
            we = ($urandom_range(0, 7) == 0);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 we, $urandom_range(0, 11), wd, 0);
        end
        idle(4);

        // Reset mid-frame: no count pulse, outputs cleared, thresholds back to defaults.
        cfgw(0, 16'hFF00); cfgw(1, 16'hFF00); cfgw(2, 16'hFF00); cfgw(3, 1);
        for (int i = 0; i < 4; i++) px(i == 0, 0, 30, 150, 200);
        reset_tick();
        idle(4);
        px(1, 1, 30, 150, 200);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
